// File: rtl/vx_lsu_gather_unit.sv
// Warp-wide load/store unit: a hold stage issues per-lane dcache requests, and a tag table
// gathers out-of-order load responses into one merged commit per instruction.
module vx_lsu_gather_unit #(
  parameter int NUM_LANES  = 4,
  parameter int QUEUE_SIZE = 4,
  parameter int WID_BITS   = 2,
  parameter int REG_BITS   = 5,
  localparam int QW        = $clog2(QUEUE_SIZE)
) (
  input  logic                      clk,
  input  logic                      reset,
  // Handshakes: a transfer happens on a rising edge where valid && ready; the source holds
  // payload stable while valid is high. st_valid is the exception: a pulse with no backpressure.
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [WID_BITS-1:0]       req_wid,
  input  logic [31:0]               req_pc,
  input  logic [NUM_LANES-1:0]      req_tmask,
  input  logic [NUM_LANES*32-1:0]   req_addr,
  input  logic [NUM_LANES*32-1:0]   req_data,
  input  logic [REG_BITS-1:0]       req_rd,
  input  logic                      req_is_load,
  input  logic [2:0]                req_fmt,
  input  logic                      req_is_fence,
  output logic [NUM_LANES-1:0]      mem_req_valid,
  input  logic [NUM_LANES-1:0]      mem_req_ready,
  output logic                      mem_req_rw,
  output logic [NUM_LANES*30-1:0]   mem_req_addr,
  output logic [NUM_LANES*4-1:0]    mem_req_byteen,
  output logic [NUM_LANES*32-1:0]   mem_req_data,
  output logic [QW-1:0]             mem_req_tag,
  input  logic                      mem_rsp_valid,
  output logic                      mem_rsp_ready,
  input  logic [NUM_LANES-1:0]      mem_rsp_tmask,
  input  logic [NUM_LANES*32-1:0]   mem_rsp_data,
  input  logic [QW-1:0]             mem_rsp_tag,
  output logic                      ld_valid,
  input  logic                      ld_ready,
  output logic [WID_BITS-1:0]       ld_wid,
  output logic [31:0]               ld_pc,
  output logic [REG_BITS-1:0]       ld_rd,
  output logic [NUM_LANES-1:0]      ld_tmask,
  output logic [NUM_LANES*32-1:0]   ld_data,
  output logic                      st_valid,
  input  logic                      st_ready,
  output logic [WID_BITS-1:0]       st_wid,
  output logic [31:0]               st_pc,
  output logic [NUM_LANES-1:0]      st_tmask,
  output logic [QW:0]               pending
);

  function automatic logic [31:0] fmt_word(input logic [31:0] raw, input logic [1:0] off,
                                           input logic [2:0] fmt);
    logic [31:0] sh;
    sh = raw >> {off, 3'b000};
    case (fmt[1:0])
      2'd0:    fmt_word = fmt[2] ? {24'b0, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
      2'd1:    fmt_word = fmt[2] ? {16'b0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
      default: fmt_word = raw;
    endcase
  endfunction

  // hold stage
  logic                    held, h_is_load, h_alloc;
  logic [WID_BITS-1:0]     h_wid;
  logic [31:0]             h_pc;
  logic [NUM_LANES-1:0]    h_tmask, h_sent;
  logic [NUM_LANES*32-1:0] h_addr, h_data;
  logic [REG_BITS-1:0]     h_rd;
  logic [2:0]              h_fmt;
  logic [QW-1:0]           h_tag;
  logic                    fence_q;
  logic [WID_BITS-1:0]     f_wid;
  logic [31:0]             f_pc;
  logic [NUM_LANES-1:0]    f_tmask;

  // tag table
  logic [QUEUE_SIZE-1:0]    e_valid, e_done, e_dup;
  logic [WID_BITS-1:0]      e_wid   [QUEUE_SIZE];
  logic [31:0]              e_pc    [QUEUE_SIZE];
  logic [REG_BITS-1:0]      e_rd    [QUEUE_SIZE];
  logic [NUM_LANES-1:0]     e_tmask [QUEUE_SIZE];
  logic [NUM_LANES-1:0]     e_rem   [QUEUE_SIZE];
  logic [2:0]               e_fmt   [QUEUE_SIZE];
  logic [2*NUM_LANES-1:0]   e_off   [QUEUE_SIZE];
  logic [NUM_LANES*32-1:0]  e_acc   [QUEUE_SIZE];

  logic                    dup, lead_found;
  logic [29:0]             lead_addr;
  logic [NUM_LANES-1:0]    lead_mask, issue_mask, eff_mask, fire;
  logic [2*NUM_LANES-1:0]  h_offs;
  logic                    dep_ok, last, alloc, tbl_full, accept, st_store;
  logic [QW-1:0]           free_idx, commit_idx;
  logic                    commit_hit, do_commit;

  always_comb begin
    dup        = 1'b1;
    lead_found = 1'b0;
    lead_mask  = '0;
    lead_addr  = '0;
    h_offs     = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      h_offs[2*i +: 2] = h_addr[i*32 +: 2];
      if (h_tmask[i] && !lead_found) begin
        lead_found   = 1'b1;
        lead_mask[i] = 1'b1;
        lead_addr    = h_addr[i*32+2 +: 30];
      end
    end
    for (int i = 0; i < NUM_LANES; i++)
      if (h_tmask[i] && (h_addr[i*32+2 +: 30] != lead_addr)) dup = 1'b0;
  end

  always_comb begin
    free_idx   = '0;
    commit_idx = '0;
    commit_hit = 1'b0;
    for (int q = QUEUE_SIZE - 1; q >= 0; q--) begin
      if (!e_valid[q]) free_idx = QW'(q);
      if (e_done[q]) begin
        commit_idx = QW'(q);
        commit_hit = 1'b1;
      end
    end
  end

  assign tbl_full      = &e_valid;
  assign issue_mask    = dup ? lead_mask : h_tmask;
  assign eff_mask      = issue_mask & ~h_sent;
  assign dep_ok        = h_is_load ? (h_alloc || !tbl_full) : st_ready;
  assign mem_req_valid = (held && dep_ok) ? eff_mask : '0;
  assign fire          = mem_req_valid & mem_req_ready;
  assign last          = held && ((eff_mask & ~fire) == '0);
  assign alloc         = held && h_is_load && !h_alloc && (fire != '0);
  assign st_store      = last && !h_is_load;
  assign mem_req_tag   = (held && h_is_load) ? (h_alloc ? h_tag : free_idx) : '0;
  assign mem_req_rw    = held && !h_is_load;
  assign mem_rsp_ready = 1'b1;
  assign do_commit     = commit_hit && (!ld_valid || ld_ready);

  // A fence also waits for the commit register so every older load has fully retired.
  assign req_ready = req_is_fence ? (!held && (pending == '0) && !ld_valid) : (!held || last);
  assign accept    = req_valid && req_ready;

  assign st_valid = fence_q || st_store;
  assign st_wid   = fence_q ? f_wid : h_wid;
  assign st_pc    = fence_q ? f_pc : h_pc;
  assign st_tmask = fence_q ? f_tmask : h_tmask;

  always_comb begin
    mem_req_addr   = '0;
    mem_req_byteen = '0;
    mem_req_data   = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      mem_req_addr[i*30 +: 30] = h_addr[i*32+2 +: 30];
      case (h_fmt[1:0])
        2'd0:    mem_req_byteen[i*4 +: 4] = 4'b0001 << h_offs[2*i +: 2];
        2'd1:    mem_req_byteen[i*4 +: 4] = 4'b0011 << h_offs[2*i +: 2];
        default: mem_req_byteen[i*4 +: 4] = 4'hF;
      endcase
      mem_req_data[i*32 +: 32] = h_data[i*32 +: 32] << {h_offs[2*i +: 2], 3'b000};
    end
  end

  // Response gather: a dup entry broadcasts the single returned word to every active lane.
  logic [31:0]             rsp_lead;
  logic                    rsp_found, rsp_take;
  logic [NUM_LANES-1:0]    rsp_wmask, rsp_rem;
  logic [NUM_LANES*32-1:0] rsp_word, rsp_bits;

  always_comb begin
    rsp_lead  = '0;
    rsp_found = 1'b0;
    rsp_word  = '0;
    rsp_bits  = '0;
    for (int i = 0; i < NUM_LANES; i++)
      if (mem_rsp_tmask[i] && !rsp_found) begin
        rsp_found = 1'b1;
        rsp_lead  = mem_rsp_data[i*32 +: 32];
      end
    rsp_wmask = e_dup[mem_rsp_tag] ? e_tmask[mem_rsp_tag] : mem_rsp_tmask;
    for (int i = 0; i < NUM_LANES; i++) begin
      rsp_word[i*32 +: 32] = fmt_word(e_dup[mem_rsp_tag] ? rsp_lead : mem_rsp_data[i*32 +: 32],
                                      e_off[mem_rsp_tag][2*i +: 2], e_fmt[mem_rsp_tag]);
      rsp_bits[i*32 +: 32] = {32{rsp_wmask[i]}};
    end
    rsp_rem  = e_rem[mem_rsp_tag] & ~mem_rsp_tmask;
    rsp_take = mem_rsp_valid && e_valid[mem_rsp_tag] && !e_done[mem_rsp_tag];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      held <= 1'b0; h_is_load <= 1'b0; h_alloc <= 1'b0; h_wid <= '0; h_pc <= '0;
      h_tmask <= '0; h_sent <= '0; h_addr <= '0; h_data <= '0; h_rd <= '0;
      h_fmt <= '0; h_tag <= '0; fence_q <= 1'b0; f_wid <= '0; f_pc <= '0; f_tmask <= '0;
    end else begin
      fence_q <= accept && req_is_fence;
      if (accept && req_is_fence) begin
        f_wid   <= req_wid;
        f_pc    <= req_pc;
        f_tmask <= req_tmask;
      end
      if (accept && !req_is_fence) begin
        held      <= 1'b1;
        h_is_load <= req_is_load;
        h_alloc   <= 1'b0;
        h_wid     <= req_wid;
        h_pc      <= req_pc;
        h_tmask   <= req_tmask;
        h_sent    <= '0;
        h_addr    <= req_addr;
        h_data    <= req_data;
        h_rd      <= req_rd;
        h_fmt     <= req_fmt;
      end else if (last) begin
        held    <= 1'b0;
        h_alloc <= 1'b0;
      end else begin
        h_sent <= h_sent | fire;
        if (alloc) begin
          h_alloc <= 1'b1;
          h_tag   <= free_idx;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      e_valid <= '0; e_done <= '0; e_dup <= '0; pending <= '0;
      for (int q = 0; q < QUEUE_SIZE; q++) begin
        e_wid[q] <= '0; e_pc[q] <= '0; e_rd[q] <= '0; e_tmask[q] <= '0;
        e_rem[q] <= '0; e_fmt[q] <= '0; e_off[q] <= '0; e_acc[q] <= '0;
      end
    end else begin
      if (alloc) begin
        e_valid[free_idx] <= 1'b1;
        e_done[free_idx]  <= 1'b0;
        e_dup[free_idx]   <= dup;
        e_wid[free_idx]   <= h_wid;
        e_pc[free_idx]    <= h_pc;
        e_rd[free_idx]    <= h_rd;
        e_tmask[free_idx] <= h_tmask;
        e_rem[free_idx]   <= issue_mask;
        e_fmt[free_idx]   <= h_fmt;
        e_off[free_idx]   <= h_offs;
        e_acc[free_idx]   <= '0;
      end
      if (rsp_take) begin
        e_acc[mem_rsp_tag] <= (e_acc[mem_rsp_tag] & ~rsp_bits) | (rsp_word & rsp_bits);
        e_rem[mem_rsp_tag] <= rsp_rem;
        if (rsp_rem == '0) e_done[mem_rsp_tag] <= 1'b1;
      end
      if (do_commit) begin
        e_valid[commit_idx] <= 1'b0;
        e_done[commit_idx]  <= 1'b0;
      end
      case ({alloc, do_commit})
        2'b10:   pending <= pending + 1'b1;
        2'b01:   pending <= pending - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ld_valid <= 1'b0; ld_wid <= '0; ld_pc <= '0; ld_rd <= '0; ld_tmask <= '0; ld_data <= '0;
    end else if (do_commit) begin
      ld_valid <= 1'b1;
      ld_wid   <= e_wid[commit_idx];
      ld_pc    <= e_pc[commit_idx];
      ld_rd    <= e_rd[commit_idx];
      ld_tmask <= e_tmask[commit_idx];
      ld_data  <= e_acc[commit_idx];
    end else if (ld_valid && ld_ready) begin
      ld_valid <= 1'b0;
    end
  end

endmodule

// File: doc/vx_lsu_gather_unit.md
# vx_lsu_gather_unit

Parametrised load/store unit for the core's memory stage. It accepts one warp-wide memory instruction per handshake and issues per-lane word requests to the data cache, with partial per-lane acceptance. Loads are tracked in a tag table of configurable depth; out-of-order, partial-lane responses are gathered there, and a single merged load commit is emitted per instruction. It sits between the issue/operand stage and the dcache request/response interfaces, and drives the load and store commit paths.

## Interface
- NUM_LANES, 4: lanes per warp request (≥1)
- QUEUE_SIZE, 4: outstanding-load table entries (power of 2, ≥2); QW = log2(QUEUE_SIZE)
- WID_BITS, 2: warp id width
- REG_BITS, 5: destination register index width
- clk  in  1  clock; all state on rising edge
- reset  in  1  asynchronous, active-high
- req_valid / req_ready  in / out  1 / 1  request handshake
- req_wid  in  WID_BITS  warp id
- req_pc  in  32  instruction PC
- req_tmask  in  NUM_LANES  active lanes
- req_addr  in  NUM_LANES*32  full byte address per lane
- req_data  in  NUM_LANES*32  store data per lane
- req_rd  in  REG_BITS  load destination
- req_is_load  in  1  1 = load, 0 = store
- req_fmt  in  3  {unsigned, size[1:0]}: size 0 = byte, 1 = half, 2 = word
- req_is_fence  in  1  fence; other fields except wid/pc/tmask ignored
- mem_req_valid / mem_req_ready  out / in  NUM_LANES each  per-lane handshake
- mem_req_rw  out  1  1 = write
- mem_req_addr  out  NUM_LANES*30  word address (addr[31:2])
- mem_req_byteen  out  NUM_LANES*4  byte enables
- mem_req_data  out  NUM_LANES*32  aligned write data
- mem_req_tag  out  QW  table index (0 for stores)
- mem_rsp_valid / mem_rsp_ready  in / out  1 / 1  response handshake
- mem_rsp_tmask  in  NUM_LANES  lanes carried by this beat
- mem_rsp_data  in  NUM_LANES*32  raw words
- mem_rsp_tag  in  QW  table index
- ld_valid / ld_ready  out / in  1 / 1  load commit handshake
- ld_wid, ld_pc, ld_rd, ld_tmask, ld_data  out  WID_BITS, 32, REG_BITS, NUM_LANES, NUM_LANES*32  merged commit
- st_valid  out  1  store/fence commit pulse; consumer must take it
- st_ready  in  1  store commit path available
- st_wid, st_pc, st_tmask  out  WID_BITS, 32, NUM_LANES
- pending  out  QW+1  allocated table entries

## Operation
- Hold stage: one request register. Accept when the hold stage is empty, or when its last lanes fire this cycle and the incoming request is not a fence.
- Fence: accepted only when the hold stage is empty and pending == 0. It produces a 1-cycle st_valid with its wid/pc/tmask on the next cycle and issues no memory requests.
- Dup coalescing: if all active lanes share addr[31:2], only the lowest active lane is issued. Its response is broadcast to all active lanes.
- Issue mask: eff_mask = tmask (or the lowest lane if dup) & ~sent. mem_req_valid[i] = held & eff_mask[i] & dep_ok.
  - Load dep_ok: an entry is already allocated, or the table is not full.
  - Store dep_ok: st_ready.
- Allocation: on the first cycle any load lane fires, the lowest free entry is claimed. The entry stores wid, pc, rd, tmask, fmt, byte offsets, dup flag, and remaining = issued mask. That index is held as tag until every lane is sent.
- sent accumulates fired lanes. The hold stage clears when all eff lanes have fired; for stores, st_valid pulses that same cycle.
- Store formatting: byteen = 4'b0001<<off (byte), 4'b0011<<off (half), 4'hF (word); data = req_data<<(8*off). Alignment is not checked.
- Responses: mem_rsp_ready is constant 1.
  - Each beat formats its lanes (select byte/half by offset; sign-extend unless unsigned) into the entry accumulator and clears those lanes in remaining.
  - With remaining == 0, the entry is marked done.
- Commit: when the output register is empty or firing, the lowest-index done entry is loaded into it and freed. ld_tmask equals the original tmask.

## Timing
- Reset values: all valids 0, ld_*/st_* data 0, pending 0, table empty, req_ready 1, mem_rsp_ready 1.
- Reset asserted mid-operation discards all entries and in-flight state immediately.
- Load latency: request accepted at edge 0 → mem_req_valid in cycle 1. Final response beat accepted at edge k → done set at k+1 → ld_valid from cycle k+2 (no older done entries).
- Back-to-back full-ready requests issue one per cycle.
- pending increments at allocation and decrements at commit selection. Simultaneous alloc + free leaves it unchanged.
- A freed entry is reallocatable on the cycle after it is freed.
- Table full: load lanes stall with no mem_req_valid; stores continue.
- ld_valid holds with stable data until ld_ready.

## Test plan
- Word load, tmask 4'b1111, addresses 0x100/0x104/0x108/0x10C; 4 responses arrive in reverse order, one lane each → exactly one ld_valid with data in the correct lanes, pending 1→0.
- Dup load: all lanes at 0x200 with LBU at offsets 0..3, mem returns 0x8899AABB → only lane 0 issued; ld_data = 0xBB, 0xAA, 0x99, 0x88 zero-extended. LB on lane 0 yields 0xFFFFFFBB.
- Partial acceptance: store with mem_req_ready = 4'b0101 then 4'b1010 → lanes 0 and 2 fire first, lanes 1 and 3 next cycle; a single st_valid on the second cycle; byteen for SH at offset 2 = 4'b1100.
- Table full: QUEUE_SIZE+1 loads without responses → the last has no mem_req_valid and pending = QUEUE_SIZE; one commit frees an entry and the stalled load then issues with that freed tag.
- Fence with pending = 2 → req_ready low until both load commits handshake; then st_valid pulses once.
- Async reset asserted with 3 entries pending and ld_ready low → all valids 0 immediately, pending 0, req_ready 1 after release.
